// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game datapath: colour encoding,
// packed sequence geometry and the button-capture state machine encoding.
package simon_pkg;

    typedef logic [1:0] colour_t;

    localparam colour_t COL_RED    = 2'd0;
    localparam colour_t COL_GREEN  = 2'd1;
    localparam colour_t COL_BLUE   = 2'd2;
    localparam colour_t COL_YELLOW = 2'd3;

    localparam int unsigned SEQ_W     = 32;
    localparam int unsigned MAX_STEPS = 16;

    typedef enum logic [2:0] {
        CAP_IDLE,
        CAP_ARMED,
        CAP_WAIT_PRESS,
        CAP_DEBOUNCE,
        CAP_WAIT_RELEASE,
        CAP_DONE
    } cap_state_t;

    // True when exactly one button bit is set.
    function automatic logic is_onehot(input logic [3:0] b);
        return (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
    endfunction

    // Colour code is the index of the set bit; only meaningful for one-hot input.
    function automatic colour_t onehot_colour(input logic [3:0] b);
        colour_t c;
        c = COL_RED;
        if (b[1]) c = COL_GREEN;
        if (b[2]) c = COL_BLUE;
        if (b[3]) c = COL_YELLOW;
        return c;
    endfunction

endpackage

// File: rtl/player_input_capture_input_sync.sv
// Two-flop synchroniser for asynchronous button inputs.
module input_sync #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two register stages to settle metastability before the FSM sees the inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/player_input_capture.sv
// Captures debounced, validated player button presses into a packed
// 2-bit-per-step sequence word for comparison against the stored sequence.
// Optional macro INPUT_SYNC_EN inserts a 2-flop synchroniser on buttons.
module player_input_capture
    import simon_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       buttons,
    input  logic [3:0]       seq_len,
    output logic             press_valid,
    output colour_t          press_colour,
    output logic [SEQ_W-1:0] seq_out,
    output logic             complete,
    output logic             timeout,
    output logic             err_multi
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [7:0]        DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    cap_state_t        state;
    logic [3:0]        btn;
    logic [3:0]        candidate;
    logic [4:0]        count;
    logic [7:0]        deb_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [4:0]        target;

`ifdef INPUT_SYNC_EN
    input_sync #(.W(4)) u_input_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (buttons),
        .q     (btn)
    );
`else
    assign btn = buttons;
`endif

    assign target = {1'b0, seq_len} + 5'd1;

    // Capture FSM: arm on quiet buttons, debounce each press, record one-hot
    // colours, and finish on expected count or inactivity timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= CAP_IDLE;
            candidate    <= '0;
            count        <= '0;
            deb_cnt      <= '0;
            idle_cnt     <= '0;
            press_valid  <= 1'b0;
            press_colour <= COL_RED;
            seq_out      <= '0;
            complete     <= 1'b0;
            timeout      <= 1'b0;
            err_multi    <= 1'b0;
        end else begin
            press_valid <= 1'b0;
            case (state)
                CAP_IDLE: begin
                    if (en) begin
                        state     <= CAP_ARMED;
                        seq_out   <= '0;
                        count     <= '0;
                        timeout   <= 1'b0;
                        err_multi <= 1'b0;
                        deb_cnt   <= '0;
                        idle_cnt  <= '0;
                    end
                end
                CAP_DONE: begin
                    if (!en) begin
                        state    <= CAP_IDLE;
                        complete <= 1'b0;
                    end
                end
                default: begin
                    // Dropping en mid-round aborts; captured data is left in place.
                    if (!en) begin
                        state    <= CAP_IDLE;
                        deb_cnt  <= '0;
                        idle_cnt <= '0;
                    end else begin
                        case (state)
                            CAP_ARMED: begin
                                if (btn == 4'd0) begin
                                    if (deb_cnt == DEB_LAST) begin
                                        state    <= CAP_WAIT_PRESS;
                                        deb_cnt  <= '0;
                                        idle_cnt <= '0;
                                    end else begin
                                        deb_cnt <= deb_cnt + 8'd1;
                                    end
                                end else begin
                                    deb_cnt <= '0;
                                end
                            end
                            CAP_WAIT_PRESS: begin
                                if (btn != 4'd0) begin
                                    candidate <= btn;
                                    deb_cnt   <= '0;
                                    idle_cnt  <= '0;
                                    state     <= CAP_DEBOUNCE;
                                end else if (idle_cnt == IDLE_LAST) begin
                                    timeout  <= 1'b1;
                                    complete <= 1'b1;
                                    idle_cnt <= '0;
                                    state    <= CAP_DONE;
                                end else begin
                                    idle_cnt <= idle_cnt + 1'b1;
                                end
                            end
                            CAP_DEBOUNCE: begin
                                if (btn == 4'd0) begin
                                    deb_cnt <= '0;
                                    state   <= CAP_WAIT_PRESS;
                                end else if (btn != candidate) begin
                                    candidate <= btn;
                                    deb_cnt   <= '0;
                                end else if (deb_cnt == DEB_LAST) begin
                                    if (is_onehot(candidate)) begin
                                        seq_out[{count[3:0], 1'b0} +: 2] <= onehot_colour(candidate);
                                        press_colour <= onehot_colour(candidate);
                                        press_valid  <= 1'b1;
                                        count        <= count + 5'd1;
                                    end else begin
                                        err_multi <= 1'b1;
                                    end
                                    deb_cnt <= '0;
                                    state   <= CAP_WAIT_RELEASE;
                                end else begin
                                    deb_cnt <= deb_cnt + 8'd1;
                                end
                            end
                            CAP_WAIT_RELEASE: begin
                                if (btn == 4'd0) begin
                                    if (deb_cnt == DEB_LAST) begin
                                        deb_cnt <= '0;
                                        if (count == target) begin
                                            complete <= 1'b1;
                                            state    <= CAP_DONE;
                                        end else begin
                                            idle_cnt <= '0;
                                            state    <= CAP_WAIT_PRESS;
                                        end
                                    end else begin
                                        deb_cnt <= deb_cnt + 8'd1;
                                    end
                                end else begin
                                    deb_cnt <= '0;
                                end
                            end
                            default: state <= CAP_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_input_capture.sv
// Scoreboard bench for player_input_capture (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50).
module tb_player_input_capture;

    typedef struct {
        logic [31:0] seq;
        logic        to;
        logic        em;
    } round_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  buttons = 4'd0;
    logic [3:0]  seq_len = 4'd0;
    logic        press_valid;
    logic [1:0]  press_colour;
    logic [31:0] seq_out;
    logic        complete;
    logic        timeout;
    logic        err_multi;

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_col[$];
    round_t     exp_round[$];
    logic       complete_q = 1'b0;

    player_input_capture #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (50)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .buttons      (buttons),
        .seq_len      (seq_len),
        .press_valid  (press_valid),
        .press_colour (press_colour),
        .seq_out      (seq_out),
        .complete     (complete),
        .timeout      (timeout),
        .err_multi    (err_multi)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops expected colours on press_valid and round results on complete rise.
    always @(negedge clk) begin
        if (rst_n && press_valid) begin
            if (exp_col.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_press actual=%0d required=no_press", press_colour);
            end else begin
                check("press_colour", {30'd0, press_colour}, {30'd0, exp_col.pop_front()});
            end
        end
        if (rst_n && complete && !complete_q) begin
            if (exp_round.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_complete actual=1 required=0");
            end else begin
                round_t r;
                r = exp_round.pop_front();
                check("round_seq_out", seq_out, r.seq);
                check("round_timeout", {31'd0, timeout}, {31'd0, r.to});
                check("round_err_multi", {31'd0, err_multi}, {31'd0, r.em});
            end
        end
        complete_q = complete;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] b, input int hold, input int gap);
        buttons = b;
        tick(hold);
        buttons = 4'd0;
        tick(gap);
    endtask

    task automatic start_round(input logic [3:0] len);
        seq_len = len;
        en = 1'b1;
        tick(8);
    endtask

    task automatic end_round();
        int i;
        i = 0;
        while (!complete && i < 200) begin
            tick(1);
            i++;
        end
        checks++;
        if (!complete) begin
            errors++;
            $display("FAIL complete_wait actual=0 required=1");
        end
        en = 1'b0;
        tick(1);
        check("complete_drop", {31'd0, complete}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_press_valid"}, {31'd0, press_valid}, 32'd0);
        check({tag, "_press_colour"}, {30'd0, press_colour}, 32'd0);
        check({tag, "_seq_out"}, seq_out, 32'd0);
        check({tag, "_complete"}, {31'd0, complete}, 32'd0);
        check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
        check({tag, "_err_multi"}, {31'd0, err_multi}, 32'd0);
    endtask

    initial begin
        int cyc;
        round_t r;

        // Reset state
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // Clean sequence: colours 0,2,3,1 -> 0x78
        exp_col.push_back(2'd0);
        exp_col.push_back(2'd2);
        exp_col.push_back(2'd3);
        exp_col.push_back(2'd1);
        r.seq = 32'h78; r.to = 1'b0; r.em = 1'b0;
        exp_round.push_back(r);
        start_round(4'd3);
        press(4'b0001, 10, 10);
        press(4'b0100, 10, 10);
        press(4'b1000, 10, 10);
        press(4'b0010, 10, 10);
        end_round();
        tick(2);

        // Bounce: short glitch must not be accepted
        exp_col.push_back(2'd1);
        r.seq = 32'h1; r.to = 1'b0; r.em = 1'b0;
        exp_round.push_back(r);
        start_round(4'd0);
        press(4'b0010, 2, 1);
        press(4'b0010, 10, 10);
        end_round();
        check("bounce_press_colour", {30'd0, press_colour}, 32'd1);
        tick(2);

        // Multi-button press rejected, then a valid blue press completes
        exp_col.push_back(2'd2);
        r.seq = 32'h2; r.to = 1'b0; r.em = 1'b1;
        exp_round.push_back(r);
        start_round(4'd0);
        press(4'b0011, 10, 10);
        check("multi_err_flag", {31'd0, err_multi}, 32'd1);
        check("multi_not_complete", {31'd0, complete}, 32'd0);
        press(4'b0100, 10, 10);
        end_round();
        tick(2);

        // Timeout: 4 ARMED + 50 idle cycles
        r.seq = 32'h0; r.to = 1'b1; r.em = 1'b0;
        exp_round.push_back(r);
        seq_len = 4'd3;
        en = 1'b1;
        cyc = 0;
        while (!complete && cyc < 200) begin
            tick(1);
            cyc++;
        end
        check("timeout_latency", cyc, 32'd55);
        check("timeout_flag", {31'd0, timeout}, 32'd1);
        en = 1'b0;
        tick(1);
        check("timeout_complete_drop", {31'd0, complete}, 32'd0);
        check("timeout_sticky", {31'd0, timeout}, 32'd1);
        tick(2);

        // Held-over button: ignored until released and pressed again
        exp_col.push_back(2'd2);
        r.seq = 32'h2; r.to = 1'b0; r.em = 1'b0;
        exp_round.push_back(r);
        buttons = 4'b1000;
        seq_len = 4'd0;
        en = 1'b1;
        tick(20);
        check("held_seq_out", seq_out, 32'd0);
        check("held_pending_colours", exp_col.size(), 32'd1);
        buttons = 4'd0;
        tick(10);
        press(4'b0100, 10, 10);
        end_round();
        tick(2);

        // Reset mid-round during DEBOUNCE of the second press
        exp_col.push_back(2'd3);
        start_round(4'd1);
        press(4'b1000, 10, 10);
        check("prereset_seq_out", seq_out, 32'h3);
        buttons = 4'b0010;
        tick(2);
        rst_n = 1'b0;
        en = 1'b0;
        buttons = 4'd0;
        tick(1);
        check_all_zero("midreset");
        rst_n = 1'b1;
        tick(2);

        // Clean restart after reset: colours 1,2 -> 0x9
        exp_col.push_back(2'd1);
        exp_col.push_back(2'd2);
        r.seq = 32'h9; r.to = 1'b0; r.em = 1'b0;
        exp_round.push_back(r);
        start_round(4'd1);
        press(4'b0010, 10, 10);
        press(4'b0100, 10, 10);
        end_round();
        tick(4);

        check("leftover_colours", exp_col.size(), 32'd0);
        check("leftover_rounds", exp_round.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
